// File: rtl/mult_share_ctrl_32x20_if.sv
// Bus bundle for mult_share_ctrl_32x20: requester side, multiplier side and result port.
// The controller uses the slave modport; whatever drives requests and the multiplier uses master.
interface mult_share_ctrl_32x20_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int OUT_W = 12
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*20-1:0] req_in1;
    logic [N_REQ*32-1:0] req_in2;
    logic [19:0]         mul_in1;
    logic [31:0]         mul_in2;
    logic [OUT_W-1:0]    mul_out;
    logic                res_valid;
    logic                res_ready;
    logic [ID_W-1:0]     res_id;
    logic [OUT_W-1:0]    res_data;
    logic                busy;

    modport slave (
        input  req_valid, req_in1, req_in2, mul_out, res_ready,
        output req_ready, mul_in1, mul_in2, res_valid, res_id, res_data, busy
    );

    modport master (
        output req_valid, req_in1, req_in2, mul_out, res_ready,
        input  req_ready, mul_in1, mul_in2, res_valid, res_id, res_data, busy
    );
endinterface

// File: rtl/mult_share_ctrl_32x20.sv
// Shares one registered 32x20 multiplier (truncated result) among N_REQ requesters.
// Define MULT_SHARE_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational in this state
// WAIT  | operands registered, counting down the multiplier latency
// HOLD  | result presented on the result port until accepted
module mult_share_ctrl_32x20 #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int MULT_LAT = 1,
    parameter int OUT_W    = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_share_ctrl_32x20_if.slave bus
);
    localparam int CNT_W = $clog2(MULT_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ID_W-1:0]  id_q;
    logic [19:0]      mul_in1_q;
    logic [31:0]      mul_in2_q;
    logic             res_valid_q;
    logic [ID_W-1:0]  res_id_q;
    logic [OUT_W-1:0] res_data_q;
    logic             busy_q;

    logic             gnt_found_d;
    logic [ID_W-1:0]  gnt_id_d;
    logic [N_REQ-1:0] req_ready_d;

`ifdef MULT_SHARE_FIXED_PRIO_EN
    always_comb begin
        gnt_found_d = 1'b0;
        gnt_id_d    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                gnt_found_d = 1'b1;
                gnt_id_d    = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr_q;

    // Scan far-to-near so the last hit is the first valid requester at or after rr_ptr.
    always_comb begin : rr_scan
        int idx;
        idx         = 0;
        gnt_found_d = 1'b0;
        gnt_id_d    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (bus.req_valid[idx]) begin
                gnt_found_d = 1'b1;
                gnt_id_d    = ID_W'(idx);
            end
        end
    end
`endif

    always_comb begin
        req_ready_d = '0;
        if (state_q == IDLE && gnt_found_d && !rst) begin
            req_ready_d[gnt_id_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            id_q        <= '0;
            mul_in1_q   <= '0;
            mul_in2_q   <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
`ifndef MULT_SHARE_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_found_d) begin
                        mul_in1_q <= bus.req_in1[20*gnt_id_d +: 20];
                        mul_in2_q <= bus.req_in2[32*gnt_id_d +: 32];
                        id_q      <= gnt_id_d;
                        cnt_q     <= CNT_W'(MULT_LAT);
                        busy_q    <= 1'b1;
                        state_q   <= WAIT;
`ifndef MULT_SHARE_FIXED_PRIO_EN
                        rr_ptr_q  <= (gnt_id_d == ID_W'(N_REQ - 1)) ? '0
                                                                    : gnt_id_d + ID_W'(1);
`endif
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        res_data_q  <= bus.mul_out;
                        res_id_q    <= id_q;
                        res_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_d;
    assign bus.mul_in1   = mul_in1_q;
    assign bus.mul_in2   = mul_in2_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_data  = res_data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mult_share_ctrl_32x20.sv
// Self-checking bench for mult_share_ctrl_32x20 against a behavioural arbiter/multiplier model.
// Honours MULT_SHARE_FIXED_PRIO_EN in the reference model.
module tb_mult_share_ctrl_32x20;
    localparam int N_REQ    = 4;
    localparam int ID_W     = 2;
    localparam int MULT_LAT = 1;
    localparam int OUT_W    = 12;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   m_ptr  = 0;

    logic [19:0] op1 [N_REQ];
    logic [31:0] op2 [N_REQ];

    always #5 clk = ~clk;

    mult_share_ctrl_32x20_if #(.N_REQ(N_REQ), .ID_W(ID_W), .OUT_W(OUT_W)) bus ();

    mult_share_ctrl_32x20 #(
        .N_REQ(N_REQ), .ID_W(ID_W), .MULT_LAT(MULT_LAT), .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Registered multiplier with one cycle of latency, result truncated to OUT_W bits.
    always @(posedge clk) begin
        bus.mul_out <= OUT_W'(64'(bus.mul_in1) * 64'(bus.mul_in2));
    end

    function automatic int model_pick(logic [N_REQ-1:0] v, int ptr);
`ifdef MULT_SHARE_FIXED_PRIO_EN
        for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
`else
        for (int k = 0; k < N_REQ; k++) if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
`endif
        return -1;
    endfunction

    function automatic logic [OUT_W-1:0] model_mul(logic [19:0] a, logic [31:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[OUT_W-1:0];
    endfunction

    task automatic model_grant(int g);
        m_ptr = (g + 1) % N_REQ;
    endtask

    task automatic pack_ops();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_in1[20*i +: 20] = op1[i];
            bus.req_in2[32*i +: 32] = op2[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Counts negedges until res_valid is seen; gives up after 20 and reports 20.
    task automatic wait_res(output int n);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            at_neg();
            n++;
            if (bus.res_valid) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '1;
        bus.res_ready = 1'b1;
        repeat (2) step();
        at_neg();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b want 0", bus.res_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
        checks++; if (bus.mul_in1 !== '0 || bus.mul_in2 !== '0) begin errors++; $display("FAIL reset_mul_in: got %0h/%0h want 0/0", bus.mul_in1, bus.mul_in2); end
        checks++; if (bus.res_id !== '0 || bus.res_data !== '0) begin errors++; $display("FAIL reset_res: got id %0d data %0h want 0/0", bus.res_id, bus.res_data); end
        bus.req_valid = '0;
        rst = 1'b0;
        m_ptr = 0;
        step();
    endtask

    task automatic test_single();
        int n;
        logic [OUT_W-1:0] exp;
        op1[0] = 20'd3; op2[0] = 32'd5; pack_ops();
        bus.req_valid = 4'b0001;
        at_neg();
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", bus.req_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_grant_cycle: got %0b want 0", bus.busy); end
        model_grant(0);
        exp = model_mul(op1[0], op2[0]);
        step();
        bus.req_valid = '0;
        at_neg();
        checks++; if (bus.busy !== 1'b1 || bus.req_ready !== '0) begin errors++; $display("FAIL single_wait: got busy %0b ready %b want 1/0000", bus.busy, bus.req_ready); end
        checks++; if (bus.mul_in1 !== 20'd3 || bus.mul_in2 !== 32'd5) begin errors++; $display("FAIL single_operands: got %0h/%0h want 3/5", bus.mul_in1, bus.mul_in2); end
        wait_res(n);
        checks++; if (n != MULT_LAT + 1) begin errors++; $display("FAIL single_latency: got %0d want %0d", n, MULT_LAT + 1); end
        checks++; if (bus.res_id !== 2'd0 || bus.res_data !== exp) begin errors++; $display("FAIL single_result: got id %0d data %0d want 0/%0d", bus.res_id, bus.res_data, exp); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold: got %0b want 1", bus.busy); end
        step();
        at_neg();
        checks++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_done: got busy %0b valid %0b want 0/0", bus.busy, bus.res_valid); end
        step();
    endtask

    task automatic test_truncation();
        int n;
        op1[2] = 20'h00123; op2[2] = 32'h10; pack_ops();
        bus.req_valid = 4'b0100;
        at_neg();
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL trunc_grant: got %b want 0100", bus.req_ready); end
        model_grant(2);
        step();
        bus.req_valid = '0;
        wait_res(n);
        checks++; if (n != MULT_LAT + 2) begin errors++; $display("FAIL trunc_latency: got %0d want %0d", n, MULT_LAT + 2); end
        checks++; if (bus.res_id !== 2'd2 || bus.res_data !== 12'h230) begin errors++; $display("FAIL trunc_result: got id %0d data %0h want 2/230", bus.res_id, bus.res_data); end
        step();
    endtask

    task automatic test_reset_mid_op();
        int n;
        int g;
        bit seen;
        logic [OUT_W-1:0] exp;
        for (int i = 0; i < N_REQ; i++) begin op1[i] = 20'($urandom); op2[i] = $urandom; end
        pack_ops();
        bus.req_valid = 4'b0010;
        at_neg();
        g = model_pick(4'b0010, m_ptr);
        checks++; if (bus.req_ready !== 4'(1 << g)) begin errors++; $display("FAIL midrst_grant: got %b want %b", bus.req_ready, 4'(1 << g)); end
        step();
        bus.req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ptr = 0;
        at_neg();
        checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_state: got valid %0b busy %0b want 0/0", bus.res_valid, bus.busy); end
        checks++; if (bus.mul_in1 !== '0 || bus.mul_in2 !== '0) begin errors++; $display("FAIL midrst_operands: got %0h/%0h want 0/0", bus.mul_in1, bus.mul_in2); end
        seen = 1'b0;
        repeat (6) begin at_neg(); if (bus.res_valid) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL midrst_no_result: got res_valid 1 want 0"); end
        step();
        bus.req_valid = 4'b1111;
        at_neg();
        g = model_pick(4'b1111, m_ptr);
        checks++; if (bus.req_ready !== 4'(1 << g)) begin errors++; $display("FAIL midrst_restart_grant: got %b want %b", bus.req_ready, 4'(1 << g)); end
        model_grant(g);
        exp = model_mul(op1[g], op2[g]);
        step();
        bus.req_valid = '0;
        wait_res(n);
        checks++; if (n != MULT_LAT + 2 || bus.res_id !== ID_W'(g) || bus.res_data !== exp) begin errors++; $display("FAIL midrst_restart_result: got n %0d id %0d data %0h want %0d/%0d/%0h", n, bus.res_id, bus.res_data, MULT_LAT + 2, g, exp); end
        step();
    endtask

    task automatic test_arbitration(logic [N_REQ-1:0] mask, int ngrants);
        int grants;
        int last;
        int g;
        int n;
        int exp_id [$];
        logic [OUT_W-1:0] exp_data [$];
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < N_REQ; i++) begin op1[i] = 20'($urandom); op2[i] = $urandom; end
        pack_ops();
        bus.res_ready = 1'b1;
        bus.req_valid = mask;
        grants = 0;
        last = -1;
        for (int c = 0; c < 60 && grants < ngrants; c++) begin
            at_neg();
            if (bus.res_valid && exp_id.size() > 0) begin
                checks++; if (bus.res_id !== ID_W'(exp_id[0]) || bus.res_data !== exp_data[0]) begin errors++; $display("FAIL arb_result: got id %0d data %0h want %0d/%0h", bus.res_id, bus.res_data, exp_id[0], exp_data[0]); end
                void'(exp_id.pop_front());
                void'(exp_data.pop_front());
            end
            if (bus.req_ready !== '0) begin
                g = model_pick(mask, m_ptr);
                checks++; if (bus.req_ready !== 4'(1 << g)) begin errors++; $display("FAIL arb_grant: got %b want %b", bus.req_ready, 4'(1 << g)); end
                if (last >= 0) begin
                    checks++; if (c - last != MULT_LAT + 3) begin errors++; $display("FAIL arb_interval: got %0d want %0d", c - last, MULT_LAT + 3); end
                end
                exp_id.push_back(g);
                exp_data.push_back(model_mul(op1[g], op2[g]));
                model_grant(g);
                grants++;
                last = c;
            end
            step();
        end
        checks++; if (grants != ngrants) begin errors++; $display("FAIL arb_grant_count: got %0d want %0d", grants, ngrants); end
        bus.req_valid = '0;
        if (exp_id.size() > 0) begin
            wait_res(n);
            checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== ID_W'(exp_id[0]) || bus.res_data !== exp_data[0]) begin errors++; $display("FAIL arb_last_result: got v %0b id %0d data %0h want 1/%0d/%0h", bus.res_valid, bus.res_id, bus.res_data, exp_id[0], exp_data[0]); end
        end
        step();
        step();
    endtask

    task automatic test_backpressure();
        int n;
        int g;
        logic [OUT_W-1:0] exp;
        for (int i = 0; i < N_REQ; i++) begin op1[i] = 20'($urandom); op2[i] = $urandom; end
        pack_ops();
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b0001;
        at_neg();
        g = model_pick(4'b0001, m_ptr);
        checks++; if (bus.req_ready !== 4'(1 << g)) begin errors++; $display("FAIL bp_grant: got %b want %b", bus.req_ready, 4'(1 << g)); end
        model_grant(g);
        exp = model_mul(op1[g], op2[g]);
        step();
        bus.req_valid = 4'b0010;
        wait_res(n);
        checks++; if (n != MULT_LAT + 2 || bus.res_data !== exp) begin errors++; $display("FAIL bp_first: got n %0d data %0h want %0d/%0h", n, bus.res_data, MULT_LAT + 2, exp); end
        repeat (5) begin
            step();
            at_neg();
            checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== exp || bus.res_id !== ID_W'(g) || bus.req_ready !== '0) begin errors++; $display("FAIL bp_hold: got v %0b data %0h id %0d ready %b want 1/%0h/%0d/0000", bus.res_valid, bus.res_data, bus.res_id, bus.req_ready, exp, g); end
        end
        step();
        bus.res_ready = 1'b1;
        at_neg();
        checks++; if (bus.res_valid !== 1'b1 || bus.req_ready !== '0) begin errors++; $display("FAIL bp_accept_cycle: got v %0b ready %b want 1/0000", bus.res_valid, bus.req_ready); end
        step();
        at_neg();
        g = model_pick(4'b0010, m_ptr);
        checks++; if (bus.req_ready !== 4'(1 << g) || bus.res_valid !== 1'b0) begin errors++; $display("FAIL bp_next_grant: got ready %b v %0b want %b/0", bus.req_ready, bus.res_valid, 4'(1 << g)); end
        model_grant(g);
        exp = model_mul(op1[g], op2[g]);
        step();
        bus.req_valid = '0;
        wait_res(n);
        checks++; if (bus.res_id !== ID_W'(g) || bus.res_data !== exp) begin errors++; $display("FAIL bp_next_result: got id %0d data %0h want %0d/%0h", bus.res_id, bus.res_data, g, exp); end
        step();
    endtask

    task automatic test_random();
        int n;
        int g;
        int bp;
        logic [N_REQ-1:0] mask;
        logic [OUT_W-1:0] exp;
        for (int op = 0; op < 30; op++) begin
            for (int i = 0; i < N_REQ; i++) begin op1[i] = 20'($urandom); op2[i] = $urandom; end
            pack_ops();
            mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            bus.req_valid = mask;
            bus.res_ready = 1'b1;
            at_neg();
            g = model_pick(mask, m_ptr);
            checks++; if (bus.req_ready !== 4'(1 << g)) begin errors++; $display("FAIL rand_grant op %0d: got %b want %b", op, bus.req_ready, 4'(1 << g)); end
            model_grant(g);
            exp = model_mul(op1[g], op2[g]);
            step();
            bus.req_valid = '0;
            bp = $urandom_range(0, 3);
            bus.res_ready = (bp == 0);
            wait_res(n);
            checks++; if (n != MULT_LAT + 2 || bus.res_id !== ID_W'(g) || bus.res_data !== exp) begin errors++; $display("FAIL rand_result op %0d: got n %0d id %0d data %0h want %0d/%0d/%0h", op, n, bus.res_id, bus.res_data, MULT_LAT + 2, g, exp); end
            if (bp > 0) begin
                repeat (bp) begin
                    step();
                    at_neg();
                    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== exp) begin errors++; $display("FAIL rand_hold op %0d: got v %0b data %0h want 1/%0h", op, bus.res_valid, bus.res_data, exp); end
                end
                step();
                bus.res_ready = 1'b1;
                at_neg();
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        bus.req_in1 = '0;
        bus.req_in2 = '0;
        for (int i = 0; i < N_REQ; i++) begin op1[i] = '0; op2[i] = '0; end
        test_reset();
        test_single();
        test_truncation();
        test_reset_mid_op();
        test_arbitration(4'b1111, 5);
        test_arbitration(4'b1010, 4);
        test_backpressure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
